// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_if
// Brief    : Instruction-memory req/ack bus between the fetch stage and imem.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : MIPS instruction fetch with a one-entry skid buffer and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         stall,
    input  wire logic         flush,
    input  wire logic         redirect_valid,
    input  wire logic [31:0]  redirect_pc,
    if_id_stage_if.master     imem,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_op,
    output logic [5:0]        id_funct,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4,
    output logic              id_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [31:0] c_NOP = 32'h0000_0000;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_hold_instr;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic        r_id_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_fetch_addr_nxt;
    logic [31:0] w_hold_nxt;
    logic        w_load_fetch;
    logic        w_deliver;
    logic [31:0] w_deliver_word;
    logic [31:0] w_target;
    logic [31:0] w_fetch_plus4;
    logic        w_discard;
    logic        w_ack;
    logic        w_unused_bits;

    assign w_target      = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = &{1'b0, redirect_pc[1:0]};
    assign w_fetch_plus4 = r_fetch_addr + 32'd4;
    assign w_discard     = redirect_valid | flush;
    assign w_ack         = imem.imem_ack;

    // Request is live exactly in the states that own an outstanding transaction.
    assign imem.imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
    assign imem.imem_addr = r_fetch_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_nxt     = r_hold_instr;
        w_load_fetch   = 1'b0;
        w_deliver      = 1'b0;
        w_deliver_word = r_hold_instr;

        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                end
                w_state_nxt  = S_FETCH;
                w_load_fetch = 1'b1;
            end

            S_FETCH: begin
                if (w_ack) begin
                    if (w_discard) begin
                        if (redirect_valid) begin
                            w_pc_nxt = w_target;
                        end
                        w_load_fetch = 1'b1;
                    end else if (!stall) begin
                        w_deliver      = 1'b1;
                        w_deliver_word = imem.imem_rdata;
                        w_pc_nxt       = w_fetch_plus4;
                        w_load_fetch   = 1'b1;
                    end else begin
                        w_hold_nxt  = imem.imem_rdata;
                        w_state_nxt = S_HELD;
                    end
                end else if (redirect_valid) begin
                    // The pending request must finish at its old address.
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_DROP;
                end
            end

            S_HELD: begin
                if (w_discard) begin
                    w_pc_nxt     = redirect_valid ? w_target : r_fetch_addr;
                    w_state_nxt  = S_FETCH;
                    w_load_fetch = 1'b1;
                end else if (!stall) begin
                    w_deliver      = 1'b1;
                    w_deliver_word = r_hold_instr;
                    w_pc_nxt       = w_fetch_plus4;
                    w_state_nxt    = S_FETCH;
                    w_load_fetch   = 1'b1;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                end
                if (w_ack) begin
                    w_state_nxt  = S_FETCH;
                    w_load_fetch = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_fetch_addr_nxt = w_load_fetch ? w_pc_nxt : r_fetch_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_hold_instr <= c_NOP;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
            r_hold_instr <= w_hold_nxt;
        end
    end

    // Bubbles leave id_pc/id_pc_plus4 untouched so they still name the last real slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_instr    <= c_NOP;
            r_id_pc       <= 32'h0000_0000;
            r_id_pc_plus4 <= 32'h0000_0000;
            r_id_valid    <= 1'b0;
        end else if (flush) begin
            r_id_instr <= c_NOP;
            r_id_valid <= 1'b0;
        end else if (!stall) begin
            if (w_deliver) begin
                r_id_instr    <= w_deliver_word;
                r_id_pc       <= r_fetch_addr;
                r_id_pc_plus4 <= w_fetch_plus4;
                r_id_valid    <= 1'b1;
            end else begin
                r_id_instr <= c_NOP;
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_instr    = r_id_instr;
    assign id_op       = r_id_instr[31:26];
    assign id_rs       = r_id_instr[25:21];
    assign id_rt       = r_id_instr[20:16];
    assign id_rd       = r_id_instr[15:11];
    assign id_funct    = r_id_instr[5:0];
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_valid    = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed plus randomized bench for if_id_stage against a fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    int checks;
    int errors;

    if_id_stage_if imem_bus ();

    if_id_stage #(.RESET_PC(c_RESET_PC)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .id_instr       (id_instr),
        .id_op          (id_op),
        .id_funct       (id_funct),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_valid       (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetch stream as a small set of flags and addresses.
    bit          m_started;
    bit          m_held;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_hold;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_held    = 0;
        m_drop    = 0;
        m_pc      = c_RESET_PC;
        m_addr    = c_RESET_PC;
        m_hold    = 32'h0;
        m_instr   = 32'h0;
        m_valid   = 1'b0;
        m_idpc    = 32'h0;
        m_idpc4   = 32'h0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic rv,
                              input logic [31:0] rp, input logic ak, input logic [31:0] rd);
        logic [31:0] t;
        bit          got;
        logic [31:0] gw;
        logic [31:0] ga;
        t   = rp & ~32'd3;
        got = 0;
        gw  = 32'h0;
        ga  = 32'h0;
        if (!m_started) begin
            m_started = 1;
            if (rv) m_pc = t;
            m_addr = m_pc;
        end else if (m_held) begin
            if (rv || fl) begin
                m_pc   = rv ? t : m_addr;
                m_held = 0;
                m_addr = m_pc;
            end else if (!st) begin
                got    = 1;
                gw     = m_hold;
                ga     = m_addr;
                m_pc   = m_addr + 32'd4;
                m_held = 0;
                m_addr = m_pc;
            end
        end else if (m_drop) begin
            if (rv) m_pc = t;
            if (ak) begin
                m_drop = 0;
                m_addr = m_pc;
            end
        end else begin
            if (ak) begin
                if (rv || fl) begin
                    if (rv) m_pc = t;
                    m_addr = m_pc;
                end else if (!st) begin
                    got    = 1;
                    gw     = rd;
                    ga     = m_addr;
                    m_pc   = m_addr + 32'd4;
                    m_addr = m_pc;
                end else begin
                    m_hold = rd;
                    m_held = 1;
                end
            end else if (rv) begin
                m_pc   = t;
                m_drop = 1;
            end
        end

        if (fl) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            if (got) begin
                m_instr = gw;
                m_idpc  = ga;
                m_idpc4 = ga + 32'd4;
                m_valid = 1'b1;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        logic [31:0] ei;
        ei = m_instr;
        check({where, ".req"},    {31'h0, imem_bus.imem_req}, {31'h0, m_started && !m_held});
        check({where, ".addr"},   imem_bus.imem_addr, m_addr);
        check({where, ".instr"},  id_instr, ei);
        check({where, ".valid"},  {31'h0, id_valid}, {31'h0, m_valid});
        check({where, ".pc"},     id_pc, m_idpc);
        check({where, ".pc4"},    id_pc_plus4, m_idpc4);
        check({where, ".op"},     {26'h0, id_op}, {26'h0, ei[31:26]});
        check({where, ".rs"},     {27'h0, id_rs}, {27'h0, ei[25:21]});
        check({where, ".rt"},     {27'h0, id_rt}, {27'h0, ei[20:16]});
        check({where, ".rd"},     {27'h0, id_rd}, {27'h0, ei[15:11]});
        check({where, ".funct"},  {26'h0, id_funct}, {26'h0, ei[5:0]});
    endtask

    // Drives one cycle of inputs, advances one edge and checks against the model.
    task automatic step(input string where, input logic st, input logic fl, input logic rv,
                        input logic [31:0] rp, input logic ak, input logic [31:0] rd);
        stall               = st;
        flush               = fl;
        redirect_valid      = rv;
        redirect_pc         = rp;
        imem_bus.imem_ack   = ak;
        imem_bus.imem_rdata = rd;
        @(posedge clk);
        model_edge(st, fl, rv, rp, ak && imem_bus.imem_req, rd);
        #1;
        compare_all(where);
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        reset               = 1'b0;
        stall               = 1'b0;
        flush               = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        compare_all("rst");
        reset = 1'b1;

        // Zero-wait stream.
        step("idle", 0, 0, 0, 32'h0, 0, 32'h0);
        check("first_addr", imem_bus.imem_addr, 32'h0);
        step("f0", 0, 0, 0, 32'h0, 1, 32'h2001_0005);
        check("f0_op", {26'h0, id_op}, 32'h8);
        check("f0_rt", {27'h0, id_rt}, 32'h1);
        check("f0_pc", id_pc, 32'h0);
        check("f0_next", imem_bus.imem_addr, 32'h4);
        step("f1", 0, 0, 0, 32'h0, 1, 32'h0000_0000);
        check("f1_pc", id_pc, 32'h4);
        check("f1_pc4", id_pc_plus4, 32'h8);
        check("f1_valid", {31'h0, id_valid}, 32'h1);
        step("f2", 0, 0, 0, 32'h0, 1, 32'h0123_4567);
        step("f3", 0, 0, 0, 32'h0, 1, 32'h89AB_CDEF);

        // Stall with ack at 0x10.
        step("st0", 1, 0, 0, 32'h0, 1, 32'hDEAD_0010);
        check("st_req", {31'h0, imem_bus.imem_req}, 32'h0);
        step("st1", 1, 0, 0, 32'h0, 0, 32'h0);
        step("st2", 1, 0, 0, 32'h0, 0, 32'h0);
        step("st_rel", 0, 0, 0, 32'h0, 0, 32'h0);
        check("st_pc", id_pc, 32'h10);
        check("st_next", imem_bus.imem_addr, 32'h14);
        step("f5", 0, 0, 0, 32'h0, 1, 32'h1111_0014);
        step("f6", 0, 0, 0, 32'h0, 1, 32'h1111_0018);
        step("f7", 0, 0, 0, 32'h0, 1, 32'h1111_001C);

        // Redirect while the 0x20 request is unacked.
        step("rd0", 0, 0, 1, 32'h0040_0003, 0, 32'h0);
        check("rd_hold", imem_bus.imem_addr, 32'h20);
        step("rd1", 0, 0, 0, 32'h0, 0, 32'h0);
        step("rd2", 0, 0, 0, 32'h0, 1, 32'h2222_0020);
        check("rd_drop", {31'h0, id_valid}, 32'h0);
        check("rd_next", imem_bus.imem_addr, 32'h0040_0000);

        // Flush with ack at 0x30.
        step("fl0", 0, 0, 1, 32'h0000_0030, 1, 32'h3333_0000);
        step("fl1", 0, 1, 0, 32'h0, 1, 32'h3333_0030);
        check("fl_valid", {31'h0, id_valid}, 32'h0);
        check("fl_instr", id_instr, 32'h0);
        check("fl_refetch", imem_bus.imem_addr, 32'h30);

        // Address wrap.
        step("wr0", 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4444_0000);
        step("wr1", 0, 0, 0, 32'h0, 1, 32'h4444_FFFC);
        check("wr_pc4", id_pc_plus4, 32'h0);
        check("wr_next", imem_bus.imem_addr, 32'h0);

        // Reset while in DROP.
        step("dr0", 0, 0, 0, 32'h0, 1, 32'h5555_0000);
        step("dr1", 0, 0, 1, 32'h0000_0100, 0, 32'h0);
        #3;
        reset             = 1'b0;
        imem_bus.imem_ack = 1'b0;
        #1;
        model_reset();
        compare_all("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("rs0", 0, 0, 0, 32'h0, 0, 32'h0);
        check("rs_addr", imem_bus.imem_addr, c_RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic        st;
            logic        fl;
            logic        rv;
            logic [31:0] rp;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 9) == 0);
            rp = $urandom;
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            step("rnd", st, fl, rv, rp, ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline CPU. It holds the PC and issues requests to instruction memory over a req/ack handshake. It registers each fetched word together with its PC and PC+4, and presents the decoded fields (op, funct, rt, rs, rd) to the ID-stage control decoder. Stall, flush and branch/jump redirect come from the hazard unit and the branch/jump resolution logic.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  ID stage cannot accept a new instruction; hold the IF/ID register.
- flush  input  1  replace the IF/ID contents with a NOP bubble.
- redirect_valid  input  1  change the fetch stream to redirect_pc.
- redirect_pc  input  32  branch/jump target; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; held stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  instruction valid on imem_rdata this cycle; only meaningful while imem_req=1.
- imem_rdata  input  32  fetched instruction word.
- id_instr  output  32  registered instruction.
- id_op, id_funct  output  6  id_instr[31:26], id_instr[5:0].
- id_rs, id_rt, id_rd  output  5  id_instr[25:21], [20:16], [15:11].
- id_pc, id_pc_plus4  output  32  PC of id_instr and that PC + 4.
- id_valid  output  1  id_instr is a real instruction, not a bubble.

## Operation
- Registers:
  - pc: next address to fetch.
  - fetch_addr: drives imem_addr.
  - hold_instr: one-entry skid buffer.
  - state: IDLE / FETCH / HELD / DROP.
  - IF/ID register: id_instr, id_pc, id_pc_plus4, id_valid.
- Definitions:
  - "Deliver" writes the IF/ID register with id_instr=word, id_pc=fetch_addr, id_pc_plus4=fetch_addr+4 and id_valid=1, then sets pc to fetch_addr+4.
  - "Bubble" sets id_instr=0 (sll $0,$0,0) and id_valid=0; id_pc and id_pc_plus4 keep their previous values.
- imem_req=1 in FETCH and DROP, 0 otherwise. On entry to FETCH, fetch_addr is loaded with pc.
- IDLE: the only state after reset. Go to FETCH on the next edge. A redirect in IDLE loads pc=redirect_pc.
- FETCH:
  - ack & (redirect | flush): discard the word. pc gets redirect_pc if redirect, otherwise stays unchanged (re-fetch). Stay in FETCH.
  - ack & !stall: deliver imem_rdata; stay in FETCH (back-to-back fetches allowed).
  - ack & stall: hold_instr=imem_rdata; go to HELD.
  - !ack & redirect: pc=redirect_pc; go to DROP. The outstanding request keeps its old fetch_addr.
  - !ack & !redirect: wait.
- HELD:
  - redirect | flush: discard hold_instr. pc gets redirect_pc if redirect, otherwise fetch_addr. Go to FETCH.
  - !stall: deliver hold_instr; go to FETCH.
  - stall: stay in HELD.
- DROP:
  - ack: discard the word; go to FETCH.
  - redirect: pc=redirect_pc (the latest redirect wins); stay in DROP.
- IF/ID register update priority:
  - flush: bubble.
  - else stall: hold all fields.
  - else deliver (if any).
  - else bubble.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 = 0.
- Simultaneous redirect and stall: redirect wins for pc/state. The IF/ID register follows the priority list above.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, state=IDLE, id_instr=0, id_valid=0, id_pc=0, id_pc_plus4=0, all id_* fields 0.
- The first request appears on the first edge after reset deasserts; imem_addr=RESET_PC.
- Latency: imem_ack at edge N results in id_instr, id_pc and id_valid updated at edge N (visible in cycle N+1).
- With zero-wait memory (ack in the same cycle as req), throughput is 1 instr/cycle.
- imem_req is never dropped between assertion and ack.
- Reset asserted mid-transaction returns to the reset state immediately. Memory shares the reset and abandons its pending request.
- All outputs are registered or decoded from registers; no combinational input-to-output paths.

## Test plan
- Reset then zero-wait memory returning 32'h2001_0005, 32'h0000_0000 → imem_addr 0, 4, 8; id_op=6'h08 with id_rt=1 and id_pc=0, then id_pc=4 and id_pc_plus4=8; id_valid=1 every cycle.
- Ack for addr 0x10 while stall=1 for 3 cycles → state HELD, imem_req=0, IF/ID held. On stall release, id_pc=0x10 next edge and the next request is to 0x14.
- Redirect to 0x0040_0003 while the request to 0x20 is unacked → imem_addr stays 0x20 until ack; that word is dropped (id_valid=0). The next request goes to 0x0040_0000.
- flush with ack in the same cycle at addr 0x30 → id_valid=0, id_instr=0; the next request re-fetches 0x30.
- redirect_pc=32'hFFFF_FFFC followed by an ack → id_pc_plus4=0 and the next fetch address is 0.
- Assert reset while in DROP → imem_req=0, pc=RESET_PC, id_valid=0 immediately. After release, fetch resumes at RESET_PC.
